// File: rtl/jarvis_fetch_unit.sv
// Purpose: fetch/issue sequencer that owns the PC and hands one instruction at a time to the control unit.
// Latency: 2 cycles per sequential instruction or jump (FETCH+ISSUE), 3 per branch (adds RESOLVE).
// Backpressure: FETCH waits on Imem_Ack indefinitely; ISSUE holds all state while Stall is high.
module jarvis_fetch_unit #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   Start,
   input  logic [ADDR_WIDTH-1:0]  Start_Addr,
   output logic                   Imem_Req,
   output logic [ADDR_WIDTH-1:0]  Imem_Addr,
   input  logic                   Imem_Ack,
   input  logic [INSTR_WIDTH-1:0] Imem_Data,
   input  logic                   Stall,
   input  logic                   Jump,
   input  logic                   Branch,
   input  logic                   Branch_Taken,
   output logic [INSTR_WIDTH-1:0] Instr,
   output logic [4:0]             Op_Code,
   output logic                   Instr_Valid,
   output logic [ADDR_WIDTH-1:0]  PC,
   output logic                   Halted,
   output logic [15:0]            Issue_Count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      ISSUE   = 3'd2,
      RESOLVE = 3'd3,
      HALT    = 3'd4
   } state_t;

   localparam logic [4:0]            OP_NOP  = 5'b11111;
   localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  pc, pc_nxt;
   logic [INSTR_WIDTH-1:0] instr, instr_nxt;
   logic [15:0]            issue_count, issue_count_nxt;

   logic [ADDR_WIDTH-1:0]  pc_inc;
   logic [ADDR_WIDTH-1:0]  instr_low;
   logic [ADDR_WIDTH-1:0]  pc_branch;
   logic [15:0]            count_sat;

   // Offset arithmetic is modulo 2^ADDR_WIDTH, so negative offsets wrap naturally.
   assign pc_inc    = pc + PC_ONE;
   assign instr_low = instr[ADDR_WIDTH-1:0];
   assign pc_branch = pc_inc + instr_low;
   assign count_sat = (issue_count == 16'hFFFF) ? issue_count : issue_count + 16'd1;

   // Outputs are either registers or pure decodes of the state register.
   assign Imem_Req    = (state == FETCH);
   assign Imem_Addr   = pc;
   assign Instr       = instr;
   assign Op_Code     = instr[INSTR_WIDTH-1 -: 5];
   assign Instr_Valid = (state == ISSUE);
   assign PC          = pc;
   assign Halted      = (state == HALT);
   assign Issue_Count = issue_count;

   // State register and datapath registers; reset drops Imem_Req immediately via state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= '0;
         instr       <= '0;
         issue_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr       <= instr_nxt;
         issue_count <= issue_count_nxt;
      end
   end

   // Next-state and next-datapath selection; everything holds unless a rule below fires.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      instr_nxt       = instr;
      issue_count_nxt = issue_count;
      case (state)
         IDLE, HALT: begin
            if (Start) begin
               pc_nxt          = Start_Addr;
               issue_count_nxt = '0;
               state_nxt       = FETCH;
            end
         end
         FETCH: begin
            if (Imem_Ack) begin
               instr_nxt = Imem_Data;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!Stall) begin
               issue_count_nxt = count_sat;
               if (Op_Code == OP_NOP) begin
                  state_nxt = HALT;
               end else if (Jump) begin
                  pc_nxt    = instr_low;
                  state_nxt = FETCH;
               end else if (Branch) begin
                  state_nxt = RESOLVE;
               end else begin
                  pc_nxt    = pc_inc;
                  state_nxt = FETCH;
               end
            end
         end
         RESOLVE: begin
            pc_nxt    = Branch_Taken ? pc_branch : pc_inc;
            state_nxt = FETCH;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jarvis_fetch_unit.sv
// Purpose: self-checking bench for jarvis_fetch_unit with a memory and control-unit model.
// Latency: each table row runs a short program from Start to Halted and checks the trace.
// Backpressure: ack delay and stall length are per-row knobs applied by the stimulus task.
`timescale 1ns/1ps
module tb_jarvis_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 32;
   localparam logic [4:0] OP_ALU = 5'b00000;
   localparam logic [4:0] OP_JMP = 5'b00001;
   localparam logic [4:0] OP_BR  = 5'b00010;
   localparam logic [4:0] OP_JB  = 5'b00011;
   localparam logic [4:0] OP_NOP = 5'b11111;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          Start = 1'b0;
   logic [AW-1:0] Start_Addr = '0;
   logic          Imem_Req;
   logic [AW-1:0] Imem_Addr;
   logic          Imem_Ack = 1'b0;
   logic [IW-1:0] Imem_Data = '0;
   logic          Stall = 1'b0;
   logic          Jump = 1'b0;
   logic          Branch = 1'b0;
   logic          Branch_Taken = 1'b0;
   logic [IW-1:0] Instr;
   logic [4:0]    Op_Code;
   logic          Instr_Valid;
   logic [AW-1:0] PC;
   logic          Halted;
   logic [15:0]   Issue_Count;

   jarvis_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
      .clock(clock), .reset(reset), .Start(Start), .Start_Addr(Start_Addr),
      .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
      .Stall(Stall), .Jump(Jump), .Branch(Branch), .Branch_Taken(Branch_Taken),
      .Instr(Instr), .Op_Code(Op_Code), .Instr_Valid(Instr_Valid), .PC(PC),
      .Halted(Halted), .Issue_Count(Issue_Count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  start;
      logic        taken;
      int          delay;   // cycles of FETCH before the ack
      int          stall;   // cycles of Stall at the start of ISSUE
      int          nf;      // number of fetches until halt
      logic [31:0] addrs;   // first four fetch addresses, first in the top byte
      int          cnt;     // Issue_Count at halt
      int          cyc;     // edges from Start to Halted
   } vec_t;

   vec_t          vecs [9];
   logic [IW-1:0] mem [0:255];
   int            n_checks = 0;
   int            n_fail = 0;
   int            ack_delay = 0;
   int            stall_len = 0;
   int            req_len = 0;
   int            val_len = 0;
   logic          ack_force = 1'b0;
   logic          taken = 1'b0;

   function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [7:0] low);
      return {op, 19'h35A5A, low};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; then memory and control-unit models respond to the registered outputs.
   task automatic step();
      @(posedge clock);
      #1;
      if (Imem_Req) req_len++; else req_len = 0;
      if (Instr_Valid) val_len++; else val_len = 0;
      Imem_Ack     = ack_force | (Imem_Req && (req_len > ack_delay));
      Imem_Data    = mem[Imem_Addr];
      Stall        = Instr_Valid && (val_len <= stall_len);
      Jump         = Instr_Valid && (Op_Code == OP_JMP || Op_Code == OP_JB);
      Branch       = Instr_Valid && (Op_Code == OP_BR || Op_Code == OP_JB);
      Branch_Taken = taken;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " Imem_Req"}, 32'(Imem_Req), 32'h0);
      chk({tag, " Imem_Addr"}, 32'(Imem_Addr), 32'h0);
      chk({tag, " PC"}, 32'(PC), 32'h0);
      chk({tag, " Instr"}, Instr, 32'h0);
      chk({tag, " Op_Code"}, 32'(Op_Code), 32'h0);
      chk({tag, " Instr_Valid"}, 32'(Instr_Valid), 32'h0);
      chk({tag, " Halted"}, 32'(Halted), 32'h0);
      chk({tag, " Issue_Count"}, 32'(Issue_Count), 32'h0);
   endtask

   task automatic run_row(input int i);
      vec_t        v;
      logic [31:0] got;
      int          nf, cyc, rq, vl;
      logic        prev;
      logic [7:0]  fa;
      bit          bad;
      v = vecs[i];
      ack_delay = v.delay;
      stall_len = v.stall;
      taken = v.taken;
      Start_Addr = v.start;
      Start = 1'b1;
      step();
      Start = 1'b0;
      got = '0; nf = 0; cyc = 0; rq = 0; vl = 0; prev = 1'b0; fa = '0; bad = 0;
      while (!Halted && cyc < 1000) begin
         if (Imem_Req && !prev) begin
            if (nf < 4) got[31-8*nf -: 8] = Imem_Addr;
            fa = Imem_Addr;
            nf++;
         end
         if (Imem_Req && Imem_Addr !== fa) bad = 1;
         prev = Imem_Req;
         if (req_len > rq) rq = req_len;
         if (val_len > vl) vl = val_len;
         step();
         cyc++;
      end
      chk($sformatf("row%0d halted", i), 32'(Halted), 32'h1);
      chk($sformatf("row%0d fetch_count", i), 32'(nf), 32'(v.nf));
      chk($sformatf("row%0d fetch_addrs", i), got, v.addrs);
      chk($sformatf("row%0d issue_count", i), 32'(Issue_Count), 32'(v.cnt));
      chk($sformatf("row%0d cycles", i), 32'(cyc), 32'(v.cyc));
      chk($sformatf("row%0d req_len", i), 32'(rq), 32'(v.delay + 1));
      chk($sformatf("row%0d valid_len", i), 32'(vl), 32'(v.stall + 1));
      chk($sformatf("row%0d addr_stable", i), 32'(bad), 32'h0);
      chk($sformatf("row%0d last_instr", i), Instr, mem[fa]);
   endtask

   initial begin
      int w;
      for (int a = 0; a < 256; a++) mem[a] = mk(OP_NOP, 8'h00);
      mem[8'h10] = mk(OP_ALU, 8'h01);
      mem[8'h11] = mk(OP_ALU, 8'h02);
      mem[8'h12] = mk(OP_ALU, 8'h03);
      mem[8'h13] = mk(OP_NOP, 8'h13);
      mem[8'h05] = mk(OP_JMP, 8'h40);
      mem[8'h40] = mk(OP_NOP, 8'h40);
      mem[8'h20] = mk(OP_BR,  8'hFC);
      mem[8'h1D] = mk(OP_NOP, 8'h1D);
      mem[8'h21] = mk(OP_NOP, 8'h21);
      mem[8'hFF] = mk(OP_ALU, 8'h77);
      mem[8'h00] = mk(OP_NOP, 8'h99);
      mem[8'h50] = mk(OP_JB,  8'h60);
      mem[8'h60] = mk(OP_NOP, 8'h60);
      mem[8'h30] = mk(OP_NOP, 8'h30);

      //         start  tk    dly str nf  addrs         cnt cyc
      vecs[0] = '{8'h10, 1'b0, 0, 0, 4, 32'h10111213, 4,  8};  // sequential
      vecs[1] = '{8'h05, 1'b0, 0, 0, 2, 32'h05400000, 2,  4};  // jump
      vecs[2] = '{8'h20, 1'b1, 0, 0, 2, 32'h201D0000, 2,  5};  // branch taken, -4
      vecs[3] = '{8'h20, 1'b0, 0, 0, 2, 32'h20210000, 2,  5};  // branch not taken
      vecs[4] = '{8'hFF, 1'b0, 0, 0, 2, 32'hFF000000, 2,  4};  // PC wrap
      vecs[5] = '{8'h50, 1'b0, 0, 0, 2, 32'h50600000, 2,  4};  // jump beats branch
      vecs[6] = '{8'h30, 1'b0, 0, 0, 1, 32'h30000000, 1,  2};  // restart from HALT
      vecs[7] = '{8'h10, 1'b0, 5, 3, 4, 32'h10111213, 4, 40};  // slow ack + stall
      vecs[8] = '{8'h30, 1'b0, 5, 3, 1, 32'h30000000, 1, 10};  // single slow instr

      // Reset state
      step();
      chk_reset("reset");
      reset = 1'b1;
      step();
      chk_reset("idle");

      // Start while in FETCH must not disturb the fetch in flight
      ack_delay = 3; stall_len = 0; taken = 1'b0;
      Start_Addr = 8'h10; Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      Start_Addr = 8'h30; Start = 1'b1;
      step();
      Start = 1'b0;
      chk("start_in_fetch addr", 32'(Imem_Addr), 32'h10);
      chk("start_in_fetch req", 32'(Imem_Req), 32'h1);
      chk("start_in_fetch count", 32'(Issue_Count), 32'h0);
      w = 0;
      while (!Halted && w < 200) begin
         step();
         w++;
      end
      chk("start_in_fetch halted", 32'(Halted), 32'h1);
      chk("start_in_fetch final_count", 32'(Issue_Count), 32'h4);
      chk("start_in_fetch final_pc", 32'(PC), 32'h13);

      for (int i = 0; i < 9; i++) run_row(i);

      // Reset during an outstanding fetch, then a stray ack after release
      ack_delay = 20; stall_len = 0;
      Start_Addr = 8'h10; Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      chk("mid_fetch req", 32'(Imem_Req), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk_reset("async_reset");
      step();
      reset = 1'b1;
      ack_force = 1'b1;
      Imem_Ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("late_ack%0d req", k), 32'(Imem_Req), 32'h0);
         chk($sformatf("late_ack%0d valid", k), 32'(Instr_Valid), 32'h0);
         chk($sformatf("late_ack%0d instr", k), Instr, 32'h0);
         chk($sformatf("late_ack%0d halted", k), 32'(Halted), 32'h0);
      end
      ack_force = 1'b0;
      Imem_Ack = 1'b0;

      // Start from IDLE still works after the reset
      run_row(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jarvis_fetch_unit.md
# jarvis_fetch_unit

Instruction fetch and issue sequencer for the Jarvis processor. It drives the 5-bit opcode into the control unit and reacts to the decoded Jump and Branch signals that come back. It owns the program counter, fetches words from instruction memory over a request/acknowledge handshake, and issues one instruction at a time. Opcode 5'b11111 (NOP, last instruction) halts the sequencer.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of the program counter and instruction-memory address
- INSTR_WIDTH, 32, instruction word width; opcode is Instr[INSTR_WIDTH-1 -: 5]

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- Start  in  1  begin execution at Start_Addr; honoured only in IDLE or HALT
- Start_Addr  in  ADDR_WIDTH  initial PC loaded on Start
- Imem_Req  out  1  fetch request, high throughout FETCH
- Imem_Addr  out  ADDR_WIDTH  fetch address, always equal to PC
- Imem_Ack  in  1  Imem_Data valid this cycle; ignored outside FETCH
- Imem_Data  in  INSTR_WIDTH  fetched instruction word
- Stall  in  1  downstream not ready; holds ISSUE
- Jump  in  1  from control unit, valid while Instr_Valid
- Branch  in  1  from control unit, valid while Instr_Valid
- Branch_Taken  in  1  branch condition from ALU, sampled in RESOLVE
- Instr  out  INSTR_WIDTH  registered issued instruction
- Op_Code  out  5  Instr[INSTR_WIDTH-1 -: 5], feeds the control unit
- Instr_Valid  out  1  high in ISSUE
- PC  out  ADDR_WIDTH  current program counter
- Halted  out  1  high in HALT
- Issue_Count  out  16  number of instructions issued since the last Start

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE, HALT.
- **IDLE:** on Start, set PC to Start_Addr, clear Issue_Count, go to FETCH.
- **FETCH:** Imem_Req=1. On Imem_Ack, latch Imem_Data into Instr and go to ISSUE. With no ack, stay in FETCH indefinitely; there is no timeout.
- **ISSUE:** Instr_Valid=1. While Stall=1, hold everything: PC, Instr and Issue_Count are unchanged and Instr_Valid stays high. The cycle with Stall=0 is the issue cycle, and it does all of the following:
  - Issue_Count increments, saturating at 16'hFFFF.
  - The next state and PC are chosen by the first matching rule:
    - Op_Code==5'b11111: go to HALT; PC is unchanged.
    - Jump=1: PC = Instr[ADDR_WIDTH-1:0], go to FETCH. Jump wins over Branch when both are high.
    - Branch=1: go to RESOLVE; PC is unchanged.
    - Otherwise: PC = PC+1, go to FETCH.
- **RESOLVE:** one cycle.
  - If Branch_Taken=1: PC = PC + 1 + Instr[ADDR_WIDTH-1:0], computed modulo 2^ADDR_WIDTH, so a two's-complement offset wraps naturally.
  - Otherwise: PC = PC+1.
  - Go to FETCH.
- **HALT:** Halted=1. Start restarts exactly as from IDLE. Otherwise stay in HALT.
- PC+1 at all-ones wraps to 0.
- Start in FETCH, ISSUE or RESOLVE is ignored.
- Reset asserted in any state, including mid-handshake: state goes to IDLE and Imem_Req drops asynchronously. Any ack arriving after release is ignored in IDLE.

## Timing
- Reset values: state IDLE; PC=0, Imem_Addr=0, Imem_Req=0, Instr=0, Op_Code=0, Instr_Valid=0, Halted=0, Issue_Count=0.
- All outputs are registered or decoded from the state register. Op_Code, Instr and Instr_Valid change only on clock edges.
- Start sampled at edge t: Imem_Req=1 and Imem_Addr=Start_Addr from t+1.
- Imem_Ack sampled at edge t: Instr_Valid=1 with the new Instr from t+1. An ack in the first FETCH cycle is legal.
- Minimum throughput: 2 cycles per sequential instruction or jump, 3 cycles per branch.
- Jump, Branch and Branch_Taken are combinational inputs and must be stable before the sampling edge.

## Test plan
- **Sequential run:** Start with Start_Addr=8'h10; memory acks every request on its first cycle.
  - Required: Imem_Addr sequence 10,11,12.
  - Instr_Valid pulses every 2nd cycle.
  - The word at 8'h13 has opcode 11111: Halted=1 and Issue_Count=4.
- **Jump:** the instruction at 8'h05 has Jump=1 and low byte 8'h40.
  - Required: the next Imem_Addr is 8'h40, with no RESOLVE cycle.
- **Branch:** the branch at 8'h20 has offset byte 8'hFC.
  - Taken: next fetch at 8'h1D.
  - Not taken: next fetch at 8'h21.
  - In both cases there are exactly 3 cycles from issue to the next Imem_Req.
- **Handshake and stall:** delay Imem_Ack by 5 cycles and hold Stall high for 3 cycles.
  - Required: Imem_Req is held for 6 cycles and Imem_Addr stays stable.
  - Instr_Valid stays high for 4 cycles.
  - Issue_Count increments once.
- **Wrap and reset:** a sequential instruction at 8'hFF leads to a fetch at 8'h00.
  - Drop reset during FETCH: all outputs are at their reset values before the next edge.
  - A late Imem_Ack after release is ignored and the state stays IDLE.
- **Restart:** Start pulsed in HALT with Start_Addr=8'h30 restarts with Issue_Count=0 and fetches from 8'h30.
  - Start pulsed while in FETCH has no effect.
